// File: rtl/jpegls_pkg.sv
// Shared types and constants for the JPEG-LS byte stuffer.
// State encoding, marker codes and stuffing widths live here.
package jpegls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_PAD    = 3'd3,
    ST_EOI_FF = 3'd4,
    ST_EOI_D9 = 3'd5
  } state_e;

  localparam logic [7:0]  MARKER_FF  = 8'hFF;
  localparam logic [7:0]  EOI_CODE   = 8'hD9;
  localparam int unsigned STUFF_BITS = 7;
  localparam int unsigned BYTE_BITS  = 8;

  // Bits consumed by the next output byte: one fewer after a 0xFF.
  function automatic logic [3:0] need_bits(input logic prev_ff);
    return prev_ff ? 4'(STUFF_BITS) : 4'(BYTE_BITS);
  endfunction

endpackage

// File: rtl/jpegls_bit_accumulator.sv
// MSB-aligned bit accumulator: appends variable-length chunks below the
// valid bits and shifts consumed bits out of the top, in the same cycle.
module jpegls_bit_accumulator #(
  parameter int unsigned DATAOUT_LENGTH = 32,
  parameter int unsigned LEN_WIDTH      = 6,
  parameter int unsigned BUF_WIDTH      = 64,
  parameter int unsigned FILL_WIDTH     = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      shift_i,
  input  logic [3:0]                shift_amt_i,
  input  logic                      append_i,
  input  logic [DATAOUT_LENGTH-1:0] data_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  output logic [BUF_WIDTH-1:0]      buf_o,
  output logic [FILL_WIDTH-1:0]     fill_o,
  output logic [FILL_WIDTH-1:0]     fill_nxt_o
);

  localparam int unsigned PAD_BITS = BUF_WIDTH - DATAOUT_LENGTH;

  logic [BUF_WIDTH-1:0]  buf_q, buf_d, shifted, chunk, mask;
  logic [FILL_WIDTH-1:0] fill_q, fill_d, fill_s;
  logic [LEN_WIDTH-1:0]  len_sat;

  // Bits below fill are kept zero, so appending is a plain OR.
  always_comb begin
    len_sat = (len_i > LEN_WIDTH'(DATAOUT_LENGTH)) ? LEN_WIDTH'(DATAOUT_LENGTH) : len_i;
    mask    = ~({BUF_WIDTH{1'b1}} >> len_sat);
    chunk   = {data_i, {PAD_BITS{1'b0}}} & mask;
    shifted = shift_i ? (buf_q << shift_amt_i) : buf_q;
    fill_s  = shift_i ? (fill_q - FILL_WIDTH'(shift_amt_i)) : fill_q;
    buf_d   = shifted;
    fill_d  = fill_s;
    if (append_i) begin
      buf_d  = shifted | (chunk >> fill_s);
      fill_d = fill_s + FILL_WIDTH'(len_sat);
    end
    if (clear_i) begin
      buf_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign buf_o      = buf_q;
  assign fill_o     = fill_q;
  assign fill_nxt_o = fill_d;

endmodule

// File: rtl/jpegls_byte_stuffer.sv
// JPEG-LS byte stuffer: serialises packed bit chunks into bytes, inserts a
// zero bit after every 0xFF, pads the tail and appends the EOI marker.
module jpegls_byte_stuffer
  import jpegls_pkg::*;
#(
  parameter int unsigned DATAOUT_LENGTH = 32,
  parameter int unsigned LEN_WIDTH      = 6,
  parameter int unsigned BUF_WIDTH      = 64,
  parameter int unsigned FILL_WIDTH     = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATAOUT_LENGTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]      in_len,
  input  logic                      in_last,
  output logic [7:0]                byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      done,
  output logic [31:0]               byte_count
);

  state_e                state_q, state_d;
  logic                  prev_ff_q, prev_ff_d;
  logic                  eoi_loaded_q, eoi_loaded_d;
  logic [7:0]            byte_out_q, byte_out_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  done_q, done_d;
  logic [31:0]           count_q, count_d;
  logic                  in_ready_q, in_ready_d;

  logic [BUF_WIDTH-1:0]  acc_buf;
  logic [FILL_WIDTH-1:0] acc_fill, acc_fill_nxt;
  logic                  acc_clear, acc_shift, acc_append;
  logic [3:0]            need;
  logic [7:0]            cand, load_val;
  logic                  load, can_extract, out_free, fire, accept;

  jpegls_bit_accumulator #(
    .DATAOUT_LENGTH(DATAOUT_LENGTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .BUF_WIDTH     (BUF_WIDTH),
    .FILL_WIDTH    (FILL_WIDTH)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (acc_clear),
    .shift_i    (acc_shift),
    .shift_amt_i(need),
    .append_i   (acc_append),
    .data_i     (in_data),
    .len_i      (in_len),
    .buf_o      (acc_buf),
    .fill_o     (acc_fill),
    .fill_nxt_o (acc_fill_nxt)
  );

  assign need        = need_bits(prev_ff_q);
  assign cand        = prev_ff_q ? {1'b0, acc_buf[BUF_WIDTH-1 -: STUFF_BITS]}
                                 : acc_buf[BUF_WIDTH-1 -: BYTE_BITS];
  assign can_extract = acc_fill >= FILL_WIDTH'(need);
  assign out_free    = !byte_valid_q || byte_ready;
  assign fire        = byte_valid_q && byte_ready;
  assign accept      = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    prev_ff_d    = prev_ff_q;
    eoi_loaded_d = eoi_loaded_q;
    done_d       = 1'b0;
    count_d      = count_q + 32'(fire);
    load         = 1'b0;
    load_val     = '0;
    acc_clear    = 1'b0;
    acc_shift    = 1'b0;
    acc_append   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          acc_clear    = 1'b1;
          prev_ff_d    = 1'b0;
          eoi_loaded_d = 1'b0;
          count_d      = '0;
        end
      end
      ST_RUN: begin
        if (can_extract && out_free) begin
          load      = 1'b1;
          load_val  = cand;
          acc_shift = 1'b1;
          prev_ff_d = (cand == MARKER_FF);
        end
        if (accept) begin
          acc_append = 1'b1;
          if (in_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (can_extract) begin
          if (out_free) begin
            load      = 1'b1;
            load_val  = cand;
            acc_shift = 1'b1;
            prev_ff_d = (cand == MARKER_FF);
          end
        end else begin
          state_d = ST_PAD;
        end
      end
      // Leftover bits, or a bare stuffing bit after a final 0xFF.
      ST_PAD: begin
        if (acc_fill != '0 || prev_ff_q) begin
          if (out_free) begin
            load      = 1'b1;
            load_val  = cand;
            acc_clear = 1'b1;
            state_d   = ST_EOI_FF;
          end
        end else begin
          acc_clear = 1'b1;
          state_d   = ST_EOI_FF;
        end
      end
      ST_EOI_FF: begin
        if (out_free) begin
          load         = 1'b1;
          load_val     = MARKER_FF;
          eoi_loaded_d = 1'b0;
          state_d      = ST_EOI_D9;
        end
      end
      ST_EOI_D9: begin
        if (!eoi_loaded_q) begin
          if (out_free) begin
            load         = 1'b1;
            load_val     = EOI_CODE;
            eoi_loaded_d = 1'b1;
          end
        end else if (fire) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          prev_ff_d    = 1'b0;
          eoi_loaded_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    byte_valid_d = load ? 1'b1 : (fire ? 1'b0 : byte_valid_q);
    byte_out_d   = load ? load_val : byte_out_q;
    in_ready_d   = (state_d == ST_RUN) &&
                   (acc_fill_nxt <= FILL_WIDTH'(BUF_WIDTH - DATAOUT_LENGTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prev_ff_q    <= 1'b0;
      eoi_loaded_q <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_ff_q    <= prev_ff_d;
      eoi_loaded_q <= eoi_loaded_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign done       = done_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_jpegls_byte_stuffer.sv
// Bench for jpegls_byte_stuffer: a bit-queue model of the stuffed stream
// is compared against every accepted output byte.
module tb_jpegls_byte_stuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        in_last;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        done;
  logic [31:0] byte_count;

  jpegls_byte_stuffer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .done      (done),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          rdy_mode   = 0;   // 0: always ready, 1: random, 2: held low
  logic [7:0]  exp_q[$];
  logic [31:0] chunk_d[$];
  logic [5:0]  chunk_l[$];
  logic        stall_prev = 1'b0;
  logic [7:0]  out_prev   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: concatenate all chunk bits, then cut bytes by the stuffing rule.
  function automatic void build_expected();
    bit         bq[$];
    bit         prev;
    int         len;
    int         need;
    int         top;
    logic [7:0] v;
    exp_q.delete();
    for (int i = 0; i < chunk_d.size(); i++) begin
      len = (chunk_l[i] > 6'd32) ? 32 : int'(chunk_l[i]);
      for (int b = 0; b < len; b++) bq.push_back(chunk_d[i][31-b]);
    end
    prev = 1'b0;
    while (bq.size() >= (prev ? 7 : 8)) begin
      need = prev ? 7 : 8;
      v = '0;
      for (int k = need - 1; k >= 0; k--) v[k] = bq.pop_front();
      exp_q.push_back(v);
      prev = (v == 8'hFF);
    end
    if (bq.size() > 0 || prev) begin
      v = '0;
      top = prev ? 6 : 7;
      for (int k = top; bq.size() > 0; k--) v[k] = bq.pop_front();
      exp_q.push_back(v);
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
  endfunction

  task automatic pin_model(input string name, input int n, input logic [63:0] lit);
    logic [63:0] sh;
    chk({name, "_model_len"}, 32'(exp_q.size()), 32'(n));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      sh = lit >> (8 * (n - 1 - i));
      chk({name, "_model_byte"}, 32'(exp_q[i]), 32'(sh[7:0]));
    end
  endtask

  // Downstream ready generator.
  initial begin
    byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ($urandom_range(0, 3) != 0);
        default: byte_ready = 1'b0;
      endcase
    end
  end

  // Output checker: every accepted byte against the model, and hold-while-stalled.
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(byte_valid), 32'd1);
        chk("hold_byte", 32'(byte_out), 32'(out_prev));
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL extra_byte: actual=%h required=none at %0t", byte_out, $time);
        end else begin
          chk("stream_byte", 32'(byte_out), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = byte_valid && !byte_ready;
      out_prev   = byte_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [31:0] d, input logic [5:0] l, input bit last,
                            input bit poke_start);
    bit ok;
    bit rdy;
    in_data  = d;
    in_len   = l;
    in_last  = last;
    in_valid = 1'b1;
    start    = poke_start;
    ok       = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL chunk_accept: actual=timeout required=accepted at %0t", $time);
    end
  endtask

  task automatic wait_done(input int nexp);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("byte_count", byte_count, 32'(nexp));
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic run_stream(input int mode, input bit pokes, input int pin_n,
                            input logic [63:0] pin_lit, input string name);
    int nexp;
    build_expected();
    nexp = exp_q.size();
    if (pin_n > 0) pin_model(name, pin_n, pin_lit);
    rdy_mode = mode;
    pulse_start();
    for (int i = 0; i < chunk_d.size(); i++) begin
      send_chunk(chunk_d[i], chunk_l[i], i == chunk_d.size() - 1,
                 pokes && ($urandom_range(0, 5) == 0));
      if (pokes) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_done(nexp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_chunks1();
    chunk_d = '{32'hAB000000, 32'hDEADBEEF};
    chunk_l = '{6'd8, 6'd0};
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_last  = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_byte_count", byte_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed streams with hand-computed byte sequences.
    set_chunks1();
    run_stream(0, 1'b0, 3, 64'hABFFD9, "t1");
    chunk_d = '{32'hFFFF0000};
    chunk_l = '{6'd16};
    run_stream(0, 1'b0, 5, 64'hFF7F80FFD9, "t2");
    chunk_d = '{32'hFF000000};
    chunk_l = '{6'd8};
    run_stream(1, 1'b0, 4, 64'hFF00FFD9, "t3");
    chunk_d = '{32'hBFFFFFFF};
    chunk_l = '{6'd3};
    run_stream(1, 1'b0, 3, 64'hA0FFD9, "t4");

    // Back-pressure: two 32-bit chunks fit, then in_ready must stay low.
    chunk_d = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    chunk_l = '{6'd32, 6'd32, 6'd32, 6'd32};
    build_expected();
    n = exp_q.size();
    chk("t5_model_len", 32'(n), 32'd18);
    rdy_mode = 2;
    pulse_start();
    send_chunk(32'h12345678, 6'd32, 1'b0, 1'b0);
    send_chunk(32'h12345678, 6'd32, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    in_len   = 6'd32;
    repeat (6) begin
      @(negedge clk);
      chk("t5_in_ready_low", 32'(in_ready), 32'd0);
      chk("t5_stalled_byte", 32'(byte_out), 32'h12);
    end
    rdy_mode = 1;
    send_chunk(32'h12345678, 6'd32, 1'b0, 1'b0);
    send_chunk(32'h12345678, 6'd32, 1'b1, 1'b0);
    wait_done(n);
    @(posedge clk);
    #1;

    // Randomized streams, biased towards 0xFF bytes and oversize lengths.
    for (int s = 0; s < 25; s++) begin
      chunk_d.delete();
      chunk_l.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 1) d[31:24] = 8'hFF;
        if ($urandom_range(0, 2) == 0) d[23:16] = 8'hFF;
        if ($urandom_range(0, 6) == 0) d = 32'hFFFFFFFF;
        chunk_d.push_back(d);
        chunk_l.push_back(($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63))
                                                      : 6'($urandom_range(0, 32)));
      end
      run_stream(s % 2, 1'b1, 0, 64'h0, "rnd");
    end

    // Reset mid-stream with a byte pending in RUN.
    exp_q.delete();
    repeat (2) begin
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h56);
      exp_q.push_back(8'h78);
    end
    rdy_mode = 0;
    pulse_start();
    send_chunk(32'h12345678, 6'd32, 1'b0, 1'b0);
    send_chunk(32'h12345678, 6'd32, 1'b0, 1'b0);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_valid", 32'(byte_valid), 32'd1);
    chk("t6_pre_count_nonzero", 32'(byte_count != 32'd0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_byte_valid", 32'(byte_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_byte_count", byte_count, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    set_chunks1();
    run_stream(0, 1'b0, 3, 64'hABFFD9, "t6_t1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
